// File: rtl/dsm_pkg.sv
// Shared types and constants for the DSM write arbiter.
`timescale 1ns/1ps
package dsm_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} dsm_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] DSM_AWPROT    = 3'b000;
  localparam int         BEAT_BYTES    = 8;
endpackage

// File: rtl/dsm_id_fifo.sv
// Small synchronous FIFO holding the requester id of every write still
// waiting for its B response.
`timescale 1ns/1ps
module dsm_id_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array, no reset needed: contents only read when count says valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dsm_wr_arbiter.sv
// Round-robin line arbiter: N_REQ DSM engines share one AXI4-Lite write
// master. A grant covers a whole line; each beat is one single-beat AW/W.
`timescale 1ns/1ps
module dsm_wr_arbiter
  import dsm_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int ADDR_WIDTH      = 49,
  parameter int BEATS_PER_LINE  = 8,
  parameter int REGION_BYTES    = 65536,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]       cfg_base,
  input  logic [N_REQ-1:0]                       cfg_en,
  input  logic [N_REQ-1:0][63:0]                 s_req_wdata,
  input  logic [N_REQ-1:0]                       s_req_valid,
  output logic [N_REQ-1:0]                       s_req_ready,
  output logic [ADDR_WIDTH-1:0]                  m_axi_awaddr,
  output logic                                   m_axi_awvalid,
  input  logic                                   m_axi_awready,
  output logic [2:0]                             m_axi_awprot,
  output logic [63:0]                            m_axi_wdata,
  output logic [7:0]                             m_axi_wstrb,
  output logic                                   m_axi_wvalid,
  input  logic                                   m_axi_wready,
  input  logic                                   m_axi_bvalid,
  input  logic [1:0]                             m_axi_bresp,
  output logic                                   m_axi_bready,
  output logic [$clog2(N_REQ)-1:0]               grant_id,
  output logic [$clog2(MAX_OUTSTANDING):0]       outstanding,
  output logic [N_REQ-1:0]                       err_sticky,
  input  logic [N_REQ-1:0]                       err_clr,
  output logic                                   spurious_b
);
  localparam int GW   = $clog2(N_REQ);
  localparam int OW   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int OFFW = $clog2(REGION_BYTES);
  localparam int BCW  = $clog2(BEATS_PER_LINE + 1);
  localparam logic [OW-1:0]  MAX_OUT   = OW'(MAX_OUTSTANDING);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS_PER_LINE - 1);

  dsm_state_e             state;
  logic [GW-1:0]          last_id;
  logic [BCW-1:0]         beat_cnt;
  logic                   aw_done, w_done;
  logic [N_REQ-1:0][OFFW-1:0] offset;

  logic                   pick_vld;
  logic [GW-1:0]          pick_id, cand;
  logic                   accept, aw_hs, w_hs, aw_fin, w_fin, beat_done, b_ok;
  logic [GW-1:0]          fifo_id;
  logic                   fifo_empty, fifo_full;
  logic [N_REQ-1:0]       err_set;

  assign m_axi_awprot = DSM_AWPROT;
  assign m_axi_bready = 1'b1;
  assign m_axi_wstrb  = m_axi_wvalid ? 8'hFF : 8'h00;

  assign aw_hs     = m_axi_awvalid && m_axi_awready;
  assign w_hs      = m_axi_wvalid && m_axi_wready;
  assign aw_fin    = aw_done || aw_hs;
  assign w_fin     = w_done || w_hs;
  assign beat_done = (state == SEND) && aw_fin && w_fin;
  assign accept    = s_req_ready[grant_id];
  // A B with nothing outstanding is dropped; the FIFO is the source of truth.
  assign b_ok      = m_axi_bvalid && !fifo_empty;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GW'((int'(last_id) + i) % N_REQ);
      if (!pick_vld && cfg_en[cand] && s_req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  // Only the granted requester sees ready, and only with outstanding headroom.
  always_comb begin
    s_req_ready = '0;
    if (state == LOAD && outstanding < MAX_OUT && !fifo_full)
      s_req_ready[grant_id] = s_req_valid[grant_id];
  end

  // Error flag set vector for the requester owning the returning B.
  always_comb begin
    err_set = '0;
    if (b_ok && m_axi_bresp != AXI_RESP_OKAY) err_set[fifo_id] = 1'b1;
  end

  // Main FSM: grant a line, load a beat, issue AW/W, repeat until line done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant_id      <= '0;
      last_id       <= GW'(N_REQ - 1);
      beat_cnt      <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          grant_id <= pick_id;
          last_id  <= pick_id;
          beat_cnt <= '0;
          state    <= LOAD;
        end
        LOAD: if (accept) begin
          m_axi_wdata   <= s_req_wdata[grant_id];
          m_axi_awaddr  <= cfg_base[grant_id] + ADDR_WIDTH'(offset[grant_id]);
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid  <= 1'b1;
          aw_done       <= 1'b0;
          w_done        <= 1'b0;
          state         <= SEND;
        end
        SEND: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            beat_cnt <= beat_cnt + 1'b1;
            state    <= (beat_cnt == LAST_BEAT) ? IDLE : LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ring offsets: advance per completed beat, park at 0 while disabled and idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (beat_done && grant_id == GW'(i))
          offset[i] <= offset[i] + OFFW'(BEAT_BYTES);
        else if (!cfg_en[i] && !(state != IDLE && grant_id == GW'(i)))
          offset[i] <= '0;
      end
    end
  end

  // Outstanding count, error flags (set beats clear) and spurious-B flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      err_sticky  <= '0;
      spurious_b  <= 1'b0;
    end else begin
      case ({aw_hs, b_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      err_sticky <= (err_sticky & ~err_clr) | err_set;
      if (m_axi_bvalid && fifo_empty) spurious_b <= 1'b1;
    end
  end

  dsm_id_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(GW)) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (aw_hs),
    .push_data (grant_id),
    .pop       (b_ok),
    .pop_data  (fifo_id),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );
endmodule

// File: tb/tb_dsm_wr_arbiter.sv
// Directed bench for dsm_wr_arbiter (2 requesters, 128-byte rings).
`timescale 1ns/1ps
module tb_dsm_wr_arbiter;
  import dsm_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0][48:0]  cfg_base;
  logic [1:0]        cfg_en;
  logic [1:0][63:0]  s_req_wdata;
  logic [1:0]        s_req_valid;
  logic [1:0]        s_req_ready;
  logic [48:0]       m_axi_awaddr;
  logic              m_axi_awvalid, m_axi_awready;
  logic [2:0]        m_axi_awprot;
  logic [63:0]       m_axi_wdata;
  logic [7:0]        m_axi_wstrb;
  logic              m_axi_wvalid, m_axi_wready;
  logic              m_axi_bvalid;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bready;
  logic [0:0]        grant_id;
  logic [4:0]        outstanding;
  logic [1:0]        err_sticky, err_clr;
  logic              spurious_b;

  int checks = 0;
  int failures = 0;

  // bench-side sources, B responder and monitors
  int          src_left [2];
  logic [31:0] seq [2];
  logic        acc [2];
  int          b_credit;
  logic        b_auto;
  logic [1:0]  b_resp_val;
  int          max_out;
  logic [48:0] aw_addr_q [$];
  logic [0:0]  aw_id_q [$];
  logic [63:0] w_data_q [$];
  logic [7:0]  w_strb_q [$];
  logic [48:0] t2_first [4];

  dsm_wr_arbiter #(
    .N_REQ(2), .ADDR_WIDTH(49), .BEATS_PER_LINE(8),
    .REGION_BYTES(128), .MAX_OUTSTANDING(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_base(cfg_base), .cfg_en(cfg_en),
    .s_req_wdata(s_req_wdata), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awprot(m_axi_awprot), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready), .grant_id(grant_id),
    .outstanding(outstanding), .err_sticky(err_sticky), .err_clr(err_clr),
    .spurious_b(spurious_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic clear_q();
    aw_addr_q.delete(); aw_id_q.delete(); w_data_q.delete(); w_strb_q.delete();
  endtask

  // Handshake monitor, sampled mid-cycle for the upcoming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_addr_q.push_back(m_axi_awaddr);
        aw_id_q.push_back(grant_id);
        if (b_auto) b_credit++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_data_q.push_back(m_axi_wdata);
        w_strb_q.push_back(m_axi_wstrb);
      end
      for (int i = 0; i < 2; i++)
        if (s_req_valid[i] && s_req_ready[i]) acc[i] = 1'b1;
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
    end
  end

  // Beat sources: data word = {requester, sequence number}.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        seq[i] = seq[i] + 1;
        src_left[i] = src_left[i] - 1;
        acc[i] = 1'b0;
      end
      s_req_valid[i] = (src_left[i] > 0);
      s_req_wdata[i] = {32'(i), seq[i]};
    end
  end

  // B responder: one response per cycle while credit remains.
  always @(posedge clk) begin
    #1;
    if (b_credit > 0) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = b_resp_val;
      b_credit     = b_credit - 1;
    end else begin
      m_axi_bvalid = 1'b0;
      m_axi_bresp  = 2'b00;
    end
  end

  initial begin
    int n, bad;
    logic [0:0] owner;
    t2_first[0] = 49'h2000; t2_first[1] = 49'h1040;
    t2_first[2] = 49'h2040; t2_first[3] = 49'h1000;
    rst = 1'b1; cfg_en = 2'b00; err_clr = 2'b00;
    cfg_base[0] = 49'h1000; cfg_base[1] = 49'h2000;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    s_req_valid = 2'b00; s_req_wdata = '0;
    for (int i = 0; i < 2; i++) begin src_left[i] = 0; seq[i] = 0; acc[i] = 1'b0; end
    b_credit = 0; b_auto = 1'b1; b_resp_val = 2'b00; max_out = 0;
    #2;
    // reset state
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_wstrb", m_axi_wstrb, 0);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_bready", m_axi_bready, 1);
    check("rst_outstanding", outstanding, 0);
    check("rst_grant", grant_id, 0);
    check("rst_err", err_sticky, 0);
    check("rst_spur", spurious_b, 0);
    check("rst_ready", s_req_ready, 0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: single line from req0
    clear_q(); max_out = 0;
    cfg_en = 2'b01; src_left[0] = 8;
    n = 0;
    while ((aw_addr_q.size() < 8 || outstanding != 0 || m_axi_awvalid) && n < 200) begin step(); n++; end
    check("t1_aw_count", aw_addr_q.size(), 8);
    check("t1_w_count", w_data_q.size(), 8);
    for (int k = 0; k < 8 && k < aw_addr_q.size(); k++)
      check($sformatf("t1_addr%0d", k), aw_addr_q[k], 64'h1000 + 64'(8*k));
    bad = 0;
    for (int k = 0; k < w_data_q.size(); k++) begin
      if (w_strb_q[k] !== 8'hFF) bad++;
      if (w_data_q[k] !== {32'd0, 32'(k)}) bad++;
    end
    check("t1_wdata_strb", bad, 0);
    check("t1_max_out", max_out, 1);
    check("t1_awprot", m_axi_awprot, 0);
    step(); step();
    check("t1_idle_ready", s_req_ready, 0);
    check("t1_idle_out", outstanding, 0);

    // 2: both requesters streaming -> whole lines alternate 1,0,1,0
    clear_q();
    cfg_en = 2'b11; src_left[0] = 16; src_left[1] = 16;
    n = 0;
    while ((aw_addr_q.size() < 32 || outstanding != 0 || m_axi_awvalid) && n < 400) begin step(); n++; end
    check("t2_aw_count", aw_addr_q.size(), 32);
    for (int l = 0; l < 4 && aw_id_q.size() >= 32; l++) begin
      owner = aw_id_q[8*l];
      bad = 0;
      for (int k = 0; k < 8; k++) begin
        if (aw_id_q[8*l+k] !== owner) bad++;
        if (w_data_q[8*l+k][32] !== owner[0]) bad++;
      end
      check($sformatf("t2_mix%0d", l), bad, 0);
      check($sformatf("t2_owner%0d", l), owner, (l % 2 == 0) ? 1 : 0);
      check($sformatf("t2_first%0d", l), aw_addr_q[8*l], t2_first[l]);
    end

    // 3: AW stalled 5 cycles while W completes
    cfg_en = 2'b00; step(); step();
    clear_q();
    m_axi_awready = 1'b0; cfg_en = 2'b01; src_left[0] = 8;
    n = 0;
    while (!m_axi_awvalid && n < 50) begin step(); n++; end
    check("t3_awvalid_up", m_axi_awvalid, 1);
    check("t3_wvalid_up", m_axi_wvalid, 1);
    check("t3_addr0", m_axi_awaddr, 64'h1000);
    step();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("t3_awvalid%0d", c), m_axi_awvalid, 1);
      check($sformatf("t3_awaddr%0d", c), m_axi_awaddr, 64'h1000);
      check($sformatf("t3_wvalid%0d", c), m_axi_wvalid, 0);
      check($sformatf("t3_ready%0d", c), s_req_ready, 0);
      check($sformatf("t3_wcnt%0d", c), w_data_q.size(), 1);
      step();
    end
    check("t3_awcnt_stall", aw_addr_q.size(), 0);
    m_axi_awready = 1'b1;
    n = 0;
    while ((aw_addr_q.size() < 8 || outstanding != 0 || m_axi_awvalid) && n < 200) begin step(); n++; end
    check("t3_aw_count", aw_addr_q.size(), 8);
    if (aw_addr_q.size() >= 2) check("t3_addr1", aw_addr_q[1], 64'h1008);

    // 5: three lines from a freshly enabled req0 -> third line wraps
    cfg_en = 2'b00; step(); step();
    clear_q();
    cfg_en = 2'b01; src_left[0] = 24;
    n = 0;
    while ((aw_addr_q.size() < 24 || outstanding != 0 || m_axi_awvalid) && n < 400) begin step(); n++; end
    check("t5_aw_count", aw_addr_q.size(), 24);
    if (aw_addr_q.size() >= 24) begin
      check("t5_line1", aw_addr_q[8], 64'h1040);
      for (int k = 0; k < 8; k++)
        check($sformatf("t5_wrap%0d", k), aw_addr_q[16+k], 64'h1000 + 64'(8*k));
    end

    // 4: B withheld -> outstanding cap
    clear_q();
    b_auto = 1'b0; src_left[0] = 24;
    for (int c = 0; c < 80; c++) step();
    check("t4_aw_cap", aw_addr_q.size(), 16);
    check("t4_out_cap", outstanding, 16);
    check("t4_ready_low", s_req_ready, 0);
    b_credit = b_credit + 1;
    for (int c = 0; c < 10; c++) step();
    check("t4_aw_one_more", aw_addr_q.size(), 17);
    check("t4_out_still", outstanding, 16);
    b_credit = b_credit + 23;
    n = 0;
    while ((aw_addr_q.size() < 24 || outstanding != 0 || m_axi_awvalid) && n < 300) begin step(); n++; end
    check("t4_aw_total", aw_addr_q.size(), 24);
    check("t4_drained", outstanding, 0);
    check("t4_no_spur", spurious_b, 0);

    // 6: error routing, clear, spurious B, async reset mid-SEND
    clear_q();
    b_auto = 1'b1; b_resp_val = 2'b10;
    check("t6_err_pre", err_sticky, 0);
    cfg_en = 2'b10; src_left[1] = 8;
    n = 0;
    while ((aw_addr_q.size() < 8 || outstanding != 0 || m_axi_awvalid) && n < 200) begin step(); n++; end
    step();
    check("t6_err_set", err_sticky, 2'b10);
    b_resp_val = 2'b00;
    err_clr = 2'b10; step(); err_clr = 2'b00;
    check("t6_err_clr", err_sticky, 0);
    b_auto = 1'b0; b_credit = 1;
    step(); step(); step();
    check("t6_spur", spurious_b, 1);
    check("t6_spur_out", outstanding, 0);
    check("t6_spur_err", err_sticky, 0);
    m_axi_awready = 1'b0; cfg_en = 2'b01; src_left[0] = 8;
    n = 0;
    while (!m_axi_awvalid && n < 50) begin step(); n++; end
    check("t6_send_up", m_axi_awvalid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_awvalid", m_axi_awvalid, 0);
    check("t6_rst_wvalid", m_axi_wvalid, 0);
    check("t6_rst_wstrb", m_axi_wstrb, 0);
    check("t6_rst_awaddr", m_axi_awaddr, 0);
    check("t6_rst_spur", spurious_b, 0);
    check("t6_rst_ready", s_req_ready, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
